// File: rtl/pipe_wb_pkg.sv
// rtl/pipe_wb_pkg.sv - depth limits, default widths and writeback payload layout for the elastic MEM/WB pipe
package pipe_wb_pkg;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;
    localparam int DEF_DATAPATH_WIDTH = 64;
    localparam int DEF_REGFILE_ADDR_WIDTH = 5;

    // Field order here is the bit order of the flattened slot payload, MSB first.
    typedef struct packed {
        logic [DEF_DATAPATH_WIDTH-1:0]     mem_data;
        logic [DEF_DATAPATH_WIDTH-1:0]     accum;
        logic [DEF_REGFILE_ADDR_WIDTH-1:0] WR_addr;
        logic                              WR_en;
        logic                              mem_reg_sel;
    } wb_payload_t;

    localparam int PAYLOAD_W = $bits(wb_payload_t);

    function automatic int payload_width(input int dw, input int aw);
        return 2 * dw + aw + 2;
    endfunction
endpackage

// File: rtl/pipe_wb_slot.sv
// rtl/pipe_wb_slot.sv - one valid bit plus payload register with load/clear/flush controls
module pipe_wb_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);
    logic         r_valid;
    logic [W-1:0] r_q;

    // Flush drops the valid bit only; the payload keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;
endmodule

// File: rtl/pipe_mem_wb_elastic.sv
// rtl/pipe_mem_wb_elastic.sv - elastic DEPTH-stage MEM/WB register chain; PIPE_WB_BYPASS_EN adds a forwarding search
module pipe_mem_wb_elastic
    import pipe_wb_pkg::*;
#(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int DEPTH              = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAPATH_WIDTH-1:0]     mem_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     accum_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          mem_reg_sel_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAPATH_WIDTH-1:0]     mem_data_out,
    output logic [DATAPATH_WIDTH-1:0]     accum_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
`ifdef PIPE_WB_BYPASS_EN
    input  logic [REGFILE_ADDR_WIDTH-1:0] fwd_addr,
    output logic                          fwd_hit,
    output logic [DATAPATH_WIDTH-1:0]     fwd_data,
`endif
    output logic                          WR_en_qual
);
    localparam int PW       = payload_width(DATAPATH_WIDTH, REGFILE_ADDR_WIDTH);
    localparam int SEL_B    = 0;
    localparam int WEN_B    = 1;
    localparam int ADDR_LSB = 2;
    localparam int ACC_LSB  = ADDR_LSB + REGFILE_ADDR_WIDTH;
    localparam int MEM_LSB  = ACC_LSB + DATAPATH_WIDTH;

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("pipe_mem_wb_elastic: DEPTH out of range");
    end

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic [PW-1:0]    w_d [DEPTH];
    logic [PW-1:0]    w_q [DEPTH];
    logic             w_out_fire;
    logic             w_accept;

    assign w_out_fire = en & w_valid[DEPTH-1] & out_ready;

    // Ready ripples from the output back to stage 0 through a running term.
    always_comb begin
        logic a;
        w_adv = '0;
        a = w_out_fire;
        w_adv[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a = w_valid[i] & (~w_valid[i+1] | a);
            w_adv[i] = a;
        end
    end

    assign in_ready = en & ~flush & (~w_valid[0] | w_adv[0]);
    assign w_accept = in_valid & in_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_d[g]    = {mem_data_in, accum_in, WR_addr_in, WR_en_in, mem_reg_sel_in};
            assign w_load[g] = w_accept;
        end else begin : g_body
            assign w_d[g]    = w_q[g-1];
            assign w_load[g] = en & ~flush & w_adv[g-1];
        end
        assign w_clear[g] = en & w_adv[g];

        pipe_wb_slot #(.W(PW)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_load  (w_load[g]),
            .i_clear (w_clear[g]),
            .i_d     (w_d[g]),
            .o_valid (w_valid[g]),
            .o_q     (w_q[g])
        );
    end

    assign out_valid       = w_valid[DEPTH-1];
    assign mem_data_out    = w_q[DEPTH-1][MEM_LSB +: DATAPATH_WIDTH];
    assign accum_out       = w_q[DEPTH-1][ACC_LSB +: DATAPATH_WIDTH];
    assign WR_addr_out     = w_q[DEPTH-1][ADDR_LSB +: REGFILE_ADDR_WIDTH];
    assign WR_en_out       = w_q[DEPTH-1][WEN_B];
    assign mem_reg_sel_out = w_q[DEPTH-1][SEL_B];
    assign WR_en_qual      = WR_en_out & w_out_fire;

`ifdef PIPE_WB_BYPASS_EN
    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_valid[i] && w_q[i][WEN_B] && (fwd_addr != '0) &&
                (w_q[i][ADDR_LSB +: REGFILE_ADDR_WIDTH] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_q[i][SEL_B] ? w_q[i][MEM_LSB +: DATAPATH_WIDTH]
                                         : w_q[i][ACC_LSB +: DATAPATH_WIDTH];
            end
        end
    end
`endif
endmodule

// File: tb/tb_pipe_mem_wb_elastic.sv
// tb/tb_pipe_mem_wb_elastic.sv - scoreboard bench for pipe_mem_wb_elastic with a queue/position reference model
module tb_pipe_mem_wb_elastic;
    import pipe_wb_pkg::*;

    localparam int DW = DEF_DATAPATH_WIDTH;
    localparam int AW = DEF_REGFILE_ADDR_WIDTH;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1, en = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] mem_data_in = '0, accum_in = '0;
    logic [AW-1:0] WR_addr_in = '0;
    logic          WR_en_in = 1'b0, mem_reg_sel_in = 1'b0;
    logic          in_ready, out_valid, WR_en_out, mem_reg_sel_out, WR_en_qual;
    logic [DW-1:0] mem_data_out, accum_out;
    logic [AW-1:0] WR_addr_out;
`ifdef PIPE_WB_BYPASS_EN
    logic [AW-1:0] fwd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    pipe_mem_wb_elastic #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mem_data_in     (mem_data_in),
        .accum_in        (accum_in),
        .WR_addr_in      (WR_addr_in),
        .WR_en_in        (WR_en_in),
        .mem_reg_sel_in  (mem_reg_sel_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .mem_data_out    (mem_data_out),
        .accum_out       (accum_out),
        .WR_addr_out     (WR_addr_out),
        .WR_en_out       (WR_en_out),
        .mem_reg_sel_out (mem_reg_sel_out),
`ifdef PIPE_WB_BYPASS_EN
        .fwd_addr        (fwd_addr),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data),
`endif
        .WR_en_qual      (WR_en_qual)
    );

    // Items accepted but not yet consumed (oldest first) and their stage positions.
    wb_payload_t exp_q[$];
    int          pos_q[$];
    wb_payload_t mon_item;
    int          errors = 0;
    int          checks = 0;
    int          fwd_force = -1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wb_payload_t mk(input int addr, input logic [DW-1:0] acc,
                                       input logic [DW-1:0] md, input bit we, input bit sel);
        wb_payload_t p;
        p.mem_data = md;
        p.accum = acc;
        p.WR_addr = AW'(addr);
        p.WR_en = we;
        p.mem_reg_sel = sel;
        return p;
    endfunction

    function automatic wb_payload_t rnd_item();
        return mk($urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // Monitor: consumes the expected head whenever the writeback port takes a payload.
    always @(negedge clk) begin
        if (!reset && en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                mon_item = exp_q.pop_front();
                chk("out_payload", {mem_data_out, accum_out, WR_addr_out, WR_en_out, mem_reg_sel_out}, mon_item);
                chk("wr_en_qual", WR_en_qual, mon_item.WR_en);
            end
        end else if (!reset) begin
            chk("wr_en_qual_idle", WR_en_qual, 0);
        end
    end

    // One clock of stimulus; items slide forward into any free slot, the head leaves on a handshake.
    task automatic cycle(input bit r, input bit f, input bit e, input bit iv, input bit ordy, input wb_payload_t it);
        int np[$];
        int lim;
        bit ov_m, fire, ir_m, acc;
`ifdef PIPE_WB_BYPASS_EN
        bit            hit_m;
        logic [DW-1:0] data_m;
`endif
        reset = r; flush = f; en = e; in_valid = iv; out_ready = ordy;
        mem_data_in = it.mem_data; accum_in = it.accum; WR_addr_in = it.WR_addr;
        WR_en_in = it.WR_en; mem_reg_sel_in = it.mem_reg_sel;
`ifdef PIPE_WB_BYPASS_EN
        fwd_addr = (fwd_force >= 0) ? AW'(fwd_force) : AW'($urandom_range(0, 7));
`endif
        ov_m = (pos_q.size() > 0) && (pos_q[0] == D - 1);
        fire = e && ov_m && ordy;
        lim = D;
        for (int k = (fire ? 1 : 0); k < pos_q.size(); k++) begin
            int p;
            p = (pos_q[k] + 1 < lim - 1) ? pos_q[k] + 1 : lim - 1;
            np.push_back(p);
            lim = p;
        end
        ir_m = e && !f && (np.size() == 0 || np[np.size()-1] >= 1);
        acc = iv && ir_m && !r;
        #1;
        chk("out_valid", out_valid, ov_m);
        chk("in_ready", in_ready, ir_m);
`ifdef PIPE_WB_BYPASS_EN
        hit_m = 1'b0;
        data_m = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].WR_en && exp_q[k].WR_addr == fwd_addr && fwd_addr != '0) begin
                hit_m = 1'b1;
                data_m = exp_q[k].mem_reg_sel ? exp_q[k].mem_data : exp_q[k].accum;
            end
        end
        chk("fwd_hit", fwd_hit, hit_m);
        chk("fwd_data", fwd_data, data_m);
`endif
        @(posedge clk);
        if (r || f) begin
            pos_q.delete();
            exp_q.delete();
        end else if (e) begin
            pos_q = np;
            if (acc) begin
                pos_q.push_back(0);
                exp_q.push_back(it);
            end
        end
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_payload"}, {mem_data_out, accum_out, WR_addr_out, WR_en_out, mem_reg_sel_out}, 0);
    endtask

    initial begin
        wb_payload_t z, a, b;
        z = '0;
        @(posedge clk);
        #1;
        cycle(1, 0, 1, 0, 0, z);
        chk_zero_outputs("reset");
        chk("reset_in_ready", in_ready, 1);

        // Single item latency.
        cycle(0, 0, 1, 1, 1, mk(5, 64'h1234, 64'h0, 1, 0));
        cycle(0, 0, 1, 0, 1, z);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_accum", accum_out, 64'h1234);
        chk("lat_wr_qual", WR_en_qual, 1);
        cycle(0, 0, 1, 0, 1, z);

        // Backpressure: two fit, third refused, then drain in order.
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(0, 0, 1, 1, 0, rnd_item());
        chk("full_in_ready", in_ready, 0);
        cycle(0, 0, 1, 1, 0, rnd_item());
        repeat (3) cycle(0, 0, 1, 0, 1, z);

        // Bubble collapse.
        a = mk(3, 64'hA, 64'h0, 1, 0);
        b = mk(4, 64'hB, 64'h0, 1, 0);
        cycle(0, 0, 1, 1, 0, a);
        cycle(0, 0, 1, 0, 0, z);
        cycle(0, 0, 1, 1, 0, b);
        chk("bubble_head", accum_out, 64'hA);
        chk("bubble_full", in_ready, 0);
        repeat (3) cycle(0, 0, 1, 0, 1, z);

        // Flush on a full pipe with a pending input.
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(0, 1, 1, 1, 0, rnd_item());
        chk("flush_out_valid", out_valid, 0);
        cycle(0, 0, 1, 0, 1, z);

        // Reset mid-stream, then one item through.
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(1, 0, 1, 0, 0, z);
        chk_zero_outputs("midreset");
        cycle(0, 0, 1, 1, 1, mk(9, 64'h77, 64'h88, 1, 1));
        cycle(0, 0, 1, 0, 1, z);
        chk("post_reset_mem", mem_data_out, 64'h88);
        cycle(0, 0, 1, 0, 1, z);

        // Global enable low freezes everything.
        cycle(0, 0, 1, 1, 0, rnd_item());
        cycle(0, 0, 0, 1, 1, rnd_item());
        cycle(0, 0, 0, 1, 1, rnd_item());
        repeat (3) cycle(0, 0, 1, 0, 1, z);

`ifdef PIPE_WB_BYPASS_EN
        cycle(0, 0, 1, 1, 0, mk(7, 64'hAA, 64'h0, 1, 0));
        cycle(0, 0, 1, 1, 0, mk(7, 64'h0, 64'hBB, 1, 1));
        fwd_force = 7;
        cycle(0, 0, 1, 0, 0, z);
        chk("fwd7_hit", fwd_hit, 1);
        chk("fwd7_data", fwd_data, 64'hBB);
        fwd_force = 0;
        cycle(0, 0, 1, 0, 0, z);
        chk("fwd0_hit", fwd_hit, 0);
        fwd_force = -1;
        repeat (3) cycle(0, 0, 1, 0, 1, z);
`endif

        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rnd_item());
        end
        repeat (D + 2) cycle(0, 0, 1, 0, 1, z);
        chk("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
